// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode constants, dec_op encoding and the default datapath types
// used by the decode queue and its decoder.
package decode_queue_pkg;

    typedef logic [31:0] ADDR_TYPE;
    typedef logic [31:0] DATA_TYPE;
    typedef logic [4:0]  REG_INDEX_TYPE;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ILLEGAL = 6'd0;
    localparam logic [OP_W-1:0] OP_LUI     = 6'd1;
    localparam logic [OP_W-1:0] OP_AUIPC   = 6'd2;
    localparam logic [OP_W-1:0] OP_JAL     = 6'd3;
    localparam logic [OP_W-1:0] OP_JALR    = 6'd4;
    localparam logic [OP_W-1:0] OP_BEQ     = 6'd5;
    localparam logic [OP_W-1:0] OP_BNE     = 6'd6;
    localparam logic [OP_W-1:0] OP_BLT     = 6'd7;
    localparam logic [OP_W-1:0] OP_BGE     = 6'd8;
    localparam logic [OP_W-1:0] OP_BLTU    = 6'd9;
    localparam logic [OP_W-1:0] OP_BGEU    = 6'd10;
    localparam logic [OP_W-1:0] OP_LB      = 6'd11;
    localparam logic [OP_W-1:0] OP_LH      = 6'd12;
    localparam logic [OP_W-1:0] OP_LW      = 6'd13;
    localparam logic [OP_W-1:0] OP_LBU     = 6'd14;
    localparam logic [OP_W-1:0] OP_LHU     = 6'd15;
    localparam logic [OP_W-1:0] OP_SB      = 6'd16;
    localparam logic [OP_W-1:0] OP_SH      = 6'd17;
    localparam logic [OP_W-1:0] OP_SW      = 6'd18;
    localparam logic [OP_W-1:0] OP_ADDI    = 6'd19;
    localparam logic [OP_W-1:0] OP_SLTI    = 6'd20;
    localparam logic [OP_W-1:0] OP_SLTIU   = 6'd21;
    localparam logic [OP_W-1:0] OP_XORI    = 6'd22;
    localparam logic [OP_W-1:0] OP_ORI     = 6'd23;
    localparam logic [OP_W-1:0] OP_ANDI    = 6'd24;
    localparam logic [OP_W-1:0] OP_SLLI    = 6'd25;
    localparam logic [OP_W-1:0] OP_SRLI    = 6'd26;
    localparam logic [OP_W-1:0] OP_SRAI    = 6'd27;
    localparam logic [OP_W-1:0] OP_ADD     = 6'd28;
    localparam logic [OP_W-1:0] OP_SUB     = 6'd29;
    localparam logic [OP_W-1:0] OP_SLL     = 6'd30;
    localparam logic [OP_W-1:0] OP_SLT     = 6'd31;
    localparam logic [OP_W-1:0] OP_SLTU    = 6'd32;
    localparam logic [OP_W-1:0] OP_XOR     = 6'd33;
    localparam logic [OP_W-1:0] OP_SRL     = 6'd34;
    localparam logic [OP_W-1:0] OP_SRA     = 6'd35;
    localparam logic [OP_W-1:0] OP_OR      = 6'd36;
    localparam logic [OP_W-1:0] OP_AND     = 6'd37;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_JALR = 3'd0;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    localparam logic [2:0] F3_LB   = 3'd0;
    localparam logic [2:0] F3_LH   = 3'd1;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_LBU  = 3'd4;
    localparam logic [2:0] F3_LHU  = 3'd5;
    localparam logic [2:0] F3_SB   = 3'd0;
    localparam logic [2:0] F3_SH   = 3'd1;
    localparam logic [2:0] F3_SW   = 3'd2;
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/inst_decode_core.sv
// Combinational RV32I decoder: one dec_op per instruction, sign-extended immediate,
// unused register fields forced to zero; an illegal encoding yields all-zero fields.
module inst_decode_core
    import decode_queue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       inst,
    output logic [OP_W-1:0]   op,
    output REG_INDEX_TYPE     rs1,
    output REG_INDEX_TYPE     rs2,
    output REG_INDEX_TYPE     rd,
    output logic [DATA_W-1:0] imm,
    output logic              illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    DATA_TYPE   imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    logic [OP_W-1:0] op_sel;
    DATA_TYPE        imm_sel;
    logic            use_rs1, use_rs2, use_rd;

    always_comb begin
        op_sel  = OP_ILLEGAL;
        imm_sel = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OPC_LUI:   begin op_sel = OP_LUI;   imm_sel = imm_u; use_rd = 1'b1; end
            OPC_AUIPC: begin op_sel = OP_AUIPC; imm_sel = imm_u; use_rd = 1'b1; end
            OPC_JAL:   begin op_sel = OP_JAL;   imm_sel = imm_j; use_rd = 1'b1; end
            OPC_JALR: begin
                if (funct3 == F3_JALR) op_sel = OP_JALR;
                imm_sel = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3)
                    F3_BEQ:  op_sel = OP_BEQ;
                    F3_BNE:  op_sel = OP_BNE;
                    F3_BLT:  op_sel = OP_BLT;
                    F3_BGE:  op_sel = OP_BGE;
                    F3_BLTU: op_sel = OP_BLTU;
                    F3_BGEU: op_sel = OP_BGEU;
                    default: op_sel = OP_ILLEGAL;
                endcase
                imm_sel = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                case (funct3)
                    F3_LB:   op_sel = OP_LB;
                    F3_LH:   op_sel = OP_LH;
                    F3_LW:   op_sel = OP_LW;
                    F3_LBU:  op_sel = OP_LBU;
                    F3_LHU:  op_sel = OP_LHU;
                    default: op_sel = OP_ILLEGAL;
                endcase
                imm_sel = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OPC_STORE: begin
                case (funct3)
                    F3_SB:   op_sel = OP_SB;
                    F3_SH:   op_sel = OP_SH;
                    F3_SW:   op_sel = OP_SW;
                    default: op_sel = OP_ILLEGAL;
                endcase
                imm_sel = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                case (funct3)
                    F3_ADD:  op_sel = OP_ADDI;
                    F3_SLT:  op_sel = OP_SLTI;
                    F3_SLTU: op_sel = OP_SLTIU;
                    F3_XOR:  op_sel = OP_XORI;
                    F3_OR:   op_sel = OP_ORI;
                    F3_AND:  op_sel = OP_ANDI;
                    F3_SLL:  op_sel = (funct7 == F7_BASE) ? OP_SLLI : OP_ILLEGAL;
                    F3_SR:   op_sel = (funct7 == F7_BASE) ? OP_SRLI :
                                      (funct7 == F7_ALT)  ? OP_SRAI : OP_ILLEGAL;
                    default: op_sel = OP_ILLEGAL;
                endcase
                imm_sel = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  op_sel = OP_ADD;
                        F3_SLL:  op_sel = OP_SLL;
                        F3_SLT:  op_sel = OP_SLT;
                        F3_SLTU: op_sel = OP_SLTU;
                        F3_XOR:  op_sel = OP_XOR;
                        F3_SR:   op_sel = OP_SRL;
                        F3_OR:   op_sel = OP_OR;
                        F3_AND:  op_sel = OP_AND;
                        default: op_sel = OP_ILLEGAL;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == F3_ADD)     op_sel = OP_SUB;
                    else if (funct3 == F3_SR) op_sel = OP_SRA;
                end
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            default: op_sel = OP_ILLEGAL;
        endcase

        // Funct-level rejects land here too, so all fields collapse in one place.
        if (op_sel == OP_ILLEGAL) begin
            imm_sel = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            use_rd  = 1'b0;
        end
    end

    always_comb begin
        imm       = {DATA_W{imm_sel[31]}};
        imm[31:0] = imm_sel;
    end

    assign op      = op_sel;
    assign illegal = (op_sel == OP_ILLEGAL);
    assign rs1     = use_rs1 ? inst[19:15] : '0;
    assign rs2     = use_rs2 ? inst[24:20] : '0;
    assign rd      = use_rd  ? inst[11:7]  : '0;

endmodule

// File: rtl/decode_queue.sv
// Decode-at-write instruction queue; head presented combinationally, one cycle after the push.
// Valid/ready both sides: if_ready drops when full (no same-cycle pop bypass), rdy_in=0 freezes.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = $bits(ADDR_TYPE),
    parameter int DATA_W    = $bits(DATA_TYPE),
    parameter int REG_IDX_W = $bits(REG_INDEX_TYPE)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 if_valid,
    input  logic [ADDR_W-1:0]    if_pc,
    input  logic [31:0]          if_inst,
    output logic                 if_ready,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [ADDR_W-1:0]    dec_pc,
    output logic [OP_W-1:0]      dec_op,
    output logic [REG_IDX_W-1:0] dec_rs1,
    output logic [REG_IDX_W-1:0] dec_rs2,
    output logic [REG_IDX_W-1:0] dec_rd,
    output logic [DATA_W-1:0]    dec_imm,
    output logic                 dec_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]    pc;
        logic [OP_W-1:0]      op;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    imm;
        logic                 illegal;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [OP_W-1:0]   core_op;
    REG_INDEX_TYPE     core_rs1, core_rs2, core_rd;
    logic [DATA_W-1:0] core_imm;
    logic              core_illegal;

    inst_decode_core #(.DATA_W(DATA_W)) u_decode (
        .inst    (if_inst),
        .op      (core_op),
        .rs1     (core_rs1),
        .rs2     (core_rs2),
        .rd      (core_rd),
        .imm     (core_imm),
        .illegal (core_illegal)
    );

    entry_t wr_entry;
    entry_t head_entry;
    logic   push, pop;

    always_comb begin
        wr_entry.pc      = if_pc;
        wr_entry.op      = core_op;
        wr_entry.rs1     = REG_IDX_W'(core_rs1);
        wr_entry.rs2     = REG_IDX_W'(core_rs2);
        wr_entry.rd      = REG_IDX_W'(core_rd);
        wr_entry.imm     = core_imm;
        wr_entry.illegal = core_illegal;
    end

    // rst_in gates every output so the whole interface reads zero while in reset.
    assign if_ready  = rst_in & rdy_in & (count_q < CNT_W'(DEPTH));
    assign dec_valid = rst_in & rdy_in & ~flush_in & (count_q != '0);
    assign push      = if_valid & if_ready & ~flush_in;
    assign pop       = dec_valid & dec_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (rdy_in) begin
            if (flush_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) begin
                    mem_d[tail_q] = wr_entry;
                    tail_d        = tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_d = head_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head_entry  = rst_in ? mem_q[head_q] : '0;
    assign dec_pc      = head_entry.pc;
    assign dec_op      = head_entry.op;
    assign dec_rs1     = head_entry.rs1;
    assign dec_rs2     = head_entry.rs2;
    assign dec_rd      = head_entry.rd;
    assign dec_imm     = head_entry.imm;
    assign dec_illegal = head_entry.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode table, full/backpressure, wrap, flush, freeze, reset.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic            clk_in = 1'b0;
    logic            rst_in, rdy_in, flush_in;
    logic            if_valid, if_ready, dec_valid, dec_ready, dec_illegal;
    logic [31:0]     if_pc, if_inst, dec_pc, dec_imm;
    logic [OP_W-1:0] dec_op;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_in = ~clk_in;

    decode_queue dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_ready    (if_ready),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_pc      (dec_pc),
        .dec_op      (dec_op),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_imm     (dec_imm),
        .dec_illegal (dec_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    localparam int NV = 9;
    logic [31:0]     v_inst [NV] = '{32'h00500093, 32'hFE20AE23, 32'hFFFFFFFF, 32'h12345237,
                                     32'h00208463, 32'hFFDFF0EF, 32'h402081B3, 32'h402091B3,
                                     32'h01012283};
    logic [OP_W-1:0] v_op   [NV] = '{OP_ADDI, OP_SW, OP_ILLEGAL, OP_LUI, OP_BEQ, OP_JAL,
                                     OP_SUB, OP_ILLEGAL, OP_LW};
    logic [4:0]      v_rd   [NV] = '{5'd1, 5'd0, 5'd0, 5'd4, 5'd0, 5'd1, 5'd3, 5'd0, 5'd5};
    logic [4:0]      v_rs1  [NV] = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd1, 5'd0, 5'd1, 5'd0, 5'd2};
    logic [4:0]      v_rs2  [NV] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 5'd2, 5'd0, 5'd0};
    logic [31:0]     v_imm  [NV] = '{32'h5, 32'hFFFFFFFC, 32'h0, 32'h12345000, 32'h8,
                                     32'hFFFFFFFC, 32'h0, 32'h0, 32'h10};
    logic            v_ill  [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int npush;
        int npop;
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        if_valid = 1'b1; if_pc = 32'h55; if_inst = 32'h00500093; dec_ready = 1'b1;
        @(negedge clk_in);
        tick;
        #1;
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_pc", dec_pc, 0);
        chk("rst_dec_op", dec_op, 0);
        rst_in = 1'b1; if_valid = 1'b0; dec_ready = 1'b0;
        #1;
        chk("idle_if_ready", if_ready, 1);
        chk("idle_dec_valid", dec_valid, 0);

        // Decode table: push one, pop it the next cycle.
        for (int i = 0; i < NV; i++) begin
            if_valid = 1'b1; if_pc = 32'(i * 4); if_inst = v_inst[i]; dec_ready = 1'b0;
            #1;
            chk($sformatf("dec%0d_push_ready", i), if_ready, 1);
            chk($sformatf("dec%0d_not_yet_valid", i), dec_valid, 0);
            tick;
            if_valid = 1'b0; dec_ready = 1'b1;
            #1;
            chk($sformatf("dec%0d_valid", i), dec_valid, 1);
            chk($sformatf("dec%0d_pc", i), dec_pc, 32'(i * 4));
            chk($sformatf("dec%0d_op", i), dec_op, v_op[i]);
            chk($sformatf("dec%0d_rd", i), dec_rd, v_rd[i]);
            chk($sformatf("dec%0d_rs1", i), dec_rs1, v_rs1[i]);
            chk($sformatf("dec%0d_rs2", i), dec_rs2, v_rs2[i]);
            chk($sformatf("dec%0d_imm", i), dec_imm, v_imm[i]);
            chk($sformatf("dec%0d_illegal", i), dec_illegal, v_ill[i]);
            tick;
        end
        dec_ready = 1'b0;
        #1 chk("dec_drained", dec_valid, 0);

        // Fill to DEPTH with no pops; the 5th push must be held, even across a pop.
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1; if_pc = 32'h100 + 32'(i * 4); if_inst = 32'h00500093;
            #1 chk($sformatf("full_push%0d_ready", i), if_ready, 1);
            tick;
        end
        if_pc = 32'h110;
        #1;
        chk("full_if_ready", if_ready, 0);
        chk("full_head_pc", dec_pc, 32'h100);
        tick;
        dec_ready = 1'b1;
        #1 chk("full_pop_if_ready", if_ready, 0);
        tick;
        if_valid = 1'b0; dec_ready = 1'b0;
        #1;
        chk("after_pop_if_ready", if_ready, 1);
        chk("after_pop_head_pc", dec_pc, 32'h104);
        dec_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1 chk($sformatf("full_drain%0d_pc", i), dec_pc, 32'h100 + 32'(i * 4));
            tick;
        end
        dec_ready = 1'b0;
        #1 chk("held_push_never_entered", dec_valid, 0);

        // Streaming with dec_ready toggling: pointers wrap, order preserved.
        npush = 0;
        npop  = 0;
        for (int cyc = 0; cyc < 100 && npop < 10; cyc++) begin
            if_valid  = (npush < 10);
            if_pc     = 32'(npush * 4);
            if_inst   = {12'(npush), 20'h00093};
            dec_ready = (cyc % 2 == 1);
            #1;
            if (dec_valid && dec_ready) begin
                chk($sformatf("wrap%0d_pc", npop), dec_pc, 32'(npop * 4));
                chk($sformatf("wrap%0d_imm", npop), dec_imm, 32'(npop));
                npop++;
            end
            if (if_valid && if_ready) npush++;
            tick;
        end
        if_valid = 1'b0; dec_ready = 1'b0;
        #1;
        chk("wrap_pop_count", npop, 10);
        chk("wrap_empty", dec_valid, 0);

        // Flush with three queued and a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            if_valid = 1'b1; if_pc = 32'h200 + 32'(i * 4); if_inst = 32'h00500093;
            tick;
        end
        if_valid = 1'b0;
        #1;
        chk("preflush_valid", dec_valid, 1);
        chk("preflush_pc", dec_pc, 32'h200);
        flush_in = 1'b1; if_valid = 1'b1; if_pc = 32'h2FC; if_inst = 32'h00700113; dec_ready = 1'b1;
        #1 chk("flush_cycle_valid", dec_valid, 0);
        tick;
        flush_in = 1'b0; if_valid = 1'b0; dec_ready = 1'b0;
        #1;
        chk("flush_empty", dec_valid, 0);
        chk("flush_if_ready", if_ready, 1);
        if_valid = 1'b1; if_pc = 32'h300; if_inst = 32'h00900193;
        tick;
        if_valid = 1'b0;
        #1;
        chk("postflush_pc", dec_pc, 32'h300);
        chk("postflush_imm", dec_imm, 32'h9);
        chk("postflush_rd", dec_rd, 5'd3);
        dec_ready = 1'b1;
        tick;
        dec_ready = 1'b0;
        #1 chk("postflush_empty", dec_valid, 0);

        // rdy_in freeze with two queued.
        if_valid = 1'b1; if_pc = 32'h400; if_inst = 32'h00100093;
        tick;
        if_pc = 32'h404; if_inst = 32'h00200093;
        tick;
        rdy_in = 1'b0; if_pc = 32'h4F0; if_inst = 32'h00300093; dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("freeze%0d_if_ready", i), if_ready, 0);
            chk($sformatf("freeze%0d_dec_valid", i), dec_valid, 0);
            tick;
        end
        rdy_in = 1'b1; if_valid = 1'b0; dec_ready = 1'b0;
        #1;
        chk("thaw_valid", dec_valid, 1);
        chk("thaw_pc", dec_pc, 32'h400);
        chk("thaw_imm", dec_imm, 32'h1);
        dec_ready = 1'b1;
        tick;
        dec_ready = 1'b0;
        #1;
        chk("thaw_second_pc", dec_pc, 32'h404);
        chk("thaw_second_valid", dec_valid, 1);

        // Reset mid-stream overrides handshakes.
        rst_in = 1'b0; if_valid = 1'b1; if_pc = 32'h500; dec_ready = 1'b1;
        #1;
        chk("midrst_if_ready", if_ready, 0);
        chk("midrst_dec_valid", dec_valid, 0);
        chk("midrst_dec_rd", dec_rd, 0);
        tick;
        #1;
        chk("midrst2_dec_valid", dec_valid, 0);
        chk("midrst2_dec_pc", dec_pc, 0);
        chk("midrst2_dec_imm", dec_imm, 0);
        rst_in = 1'b1; if_valid = 1'b0; dec_ready = 1'b0;
        #1;
        chk("postrst_empty", dec_valid, 0);
        chk("postrst_if_ready", if_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, PC width.
REQ-003 SHALL have parameter DATA_W, default 32, immediate width (>=32).
REQ-004 SHALL have parameter REG_IDX_W, default 5, register index width.
REQ-005 SHALL have port clk_in, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_in, input, 1, reset: synchronous, active-low.
REQ-007 SHALL have port rdy_in, input, 1, global enable; 0 freezes all state.
REQ-008 SHALL have port flush_in, input, 1, discard all queued entries.
REQ-009 SHALL have ports if_valid (input, 1), if_pc (input, ADDR_W) and if_inst (input, 32), the fetch-side push request.
REQ-010 SHALL have port if_ready, output, 1, queue can accept.
REQ-011 SHALL have ports dec_valid (output, 1) and dec_ready (input, 1), the issue-side handshake.
REQ-012 SHALL have ports dec_pc (output, ADDR_W), dec_op (output, OP_W), dec_rs1, dec_rs2 and dec_rd (each output, REG_IDX_W), dec_imm (output, DATA_W) and dec_illegal (output, 1).

Function
REQ-013 SHALL accept a push when if_valid && if_ready && rdy_in && !flush_in, decoding if_inst at write time and storing pc plus decoded fields at tail.
REQ-014 SHALL drive dec_* from the head entry combinationally from storage; the first dec_valid comes the cycle after the accepting edge (latency 1).
REQ-015 SHALL pop the head when dec_valid && dec_ready.
REQ-016 SHALL keep an occupancy count of width clog2(DEPTH)+1; head and tail pointers SHALL wrap modulo DEPTH.
REQ-017 SHALL drive if_ready = rdy_in && (count < DEPTH); when full, a push is refused even if a pop occurs in the same cycle.
REQ-018 SHALL drive dec_valid = rdy_in && !flush_in && (count != 0).
REQ-019 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-020 SHALL, when flush_in=1, zero count and both pointers at the next edge; a same-cycle push is discarded; flush takes priority over pop.
REQ-021 SHALL, when rdy_in=0, hold pointers, count and storage.
REQ-022 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP, together with funct3/funct7, into one dec_op code per instruction.
REQ-023 SHALL sign-extend I/S/B/U/J immediates to DATA_W; B/J immediates SHALL carry bit 0 = 0; U immediates SHALL carry the low 12 bits = 0.
REQ-024 SHALL force dec_rd=0 for STORE and BRANCH, dec_rs2=0 for formats without rs2, and dec_rs1=0 for LUI, AUIPC and JAL.
REQ-025 SHALL, for an unknown opcode or funct encoding, set dec_illegal=1, dec_op=OP_ILLEGAL and all other fields 0; the entry is still queued in order.

Reset
REQ-026 SHALL, when rst_in=0 at an edge, zero count and both pointers; storage contents need not be cleared.
REQ-027 SHALL hold every output at 0 while in reset (rst_in=0), including if_ready, dec_valid and all dec_* fields.
REQ-028 SHALL make a reset asserted mid-stream override flush_in, rdy_in and any handshake in that cycle.

Structure
REQ-029 SHALL place OP_W, all dec_op codes (including OP_ILLEGAL) and the RV32I opcode/funct3 constants in the shared package; ADDR_TYPE, DATA_TYPE and REG_INDEX_TYPE SHALL be reused from it.
REQ-030 SHALL instantiate one purely combinational sub-module, inst_decode_core, mapping inst to op, rs1, rs2, rd, imm and illegal; the queue logic lives in decode_queue.

Verification
REQ-031 SHALL cover: reset, then push pc=0x0, inst=0x00500093 -> next cycle dec_valid=1, op=ADDI, rd=1, rs1=0, imm=0x00000005.
REQ-032 SHALL cover: push sw x2,-4(x1)=0xFE20AE23 -> imm=0xFFFFFFFC, rs1=1, rs2=2, rd=0; push 0xFFFFFFFF -> dec_illegal=1, op=OP_ILLEGAL.
REQ-033 SHALL cover: dec_ready=0 with four pushes (DEPTH=4) -> if_ready=0 after the 4th accept and a 5th push is held; one pop -> if_ready=1 the following cycle.
REQ-034 SHALL cover: 10 instructions at pc 0x0..0x24 with dec_ready toggling each cycle -> all popped in order, showing pointer wrap and no loss or duplication.
REQ-035 SHALL cover: three queued entries plus flush_in=1 with a simultaneous push -> dec_valid=0 in the flush cycle, queue empty next cycle, pushed inst never appears.
REQ-036 SHALL cover: rdy_in=0 for 3 cycles with 2 entries queued -> no pushes or pops; on rdy_in=1 the same head entry is presented; rst_in=0 mid-stream -> all outputs 0 next cycle.
